// File: rtl/apb_req_arbiter_if.sv
// Requester, master-side and APB monitor signals of apb_req_arbiter.
// master: arbiter view; slave: requesters, APB master and slave view.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_err;
  logic [DATA_W-1:0]         rsp_rdata;

  logic                      transfer;
  logic                      SWRITE;
  logic [DATA_W-1:0]         SADDR;
  logic [DATA_W-1:0]         SWDATA;

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PREADY;
  logic                      PSLVERR;
  logic [DATA_W-1:0]         PRDATA;

  logic                      busy;
  logic [IDW-1:0]            grant_id;
  logic                      timeout_flag;
  logic                      timeout_clr;

  modport master (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_err, rsp_rdata,
    output transfer, SWRITE,
    output SADDR, SWDATA,
    input  PSEL, PENABLE, PREADY,
    input  PSLVERR, PRDATA,
    output busy, grant_id,
    output timeout_flag,
    input  timeout_clr
  );

  modport slave (
    output req_valid, req_write,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_err, rsp_rdata,
    input  transfer, SWRITE,
    input  SADDR, SWDATA,
    output PSEL, PENABLE, PREADY,
    output PSLVERR, PRDATA,
    input  busy, grant_id,
    input  timeout_flag,
    output timeout_clr
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters.
// Ports: PCLK, PRESETn (async low), bus (apb_req_arbiter_if.master).
module apb_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_req_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NUM_REQ-1:0] ONE = 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_PRE = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    WAIT
  } state_t;

  state_t              r_state;
  logic [IDW-1:0]      r_last;
  logic [IDW-1:0]      r_grant;
  logic [CW-1:0]       r_cnt;
  logic                r_flag;
  logic                r_transfer;
  logic                r_swrite;
  logic [DATA_W-1:0]   r_saddr;
  logic [DATA_W-1:0]   r_swdata;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_busy;

  logic                w_any;
  logic [IDW-1:0]      w_win;
  logic [IDW-1:0]      w_idx;
  int                  w_k;
  logic                w_setup;
  logic                w_done;
  logic                w_stall;
  logic                w_set;
  logic [CW-1:0]       w_cnt_nxt;

  // First valid requester at or after r_last+1, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    w_k   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = int'(r_last) + i;
      if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
      w_idx = IDW'(w_k);
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_setup = bus.PSEL && !bus.PENABLE;
  assign w_done  = (r_state == WAIT) && bus.PSEL &&
                   bus.PENABLE && bus.PREADY;
  assign w_stall = (r_state == WAIT) && bus.PENABLE &&
                   !bus.PREADY;

  assign w_cnt_nxt = (w_stall && r_cnt != TO_MAX) ?
                     r_cnt + 1'b1 : r_cnt;
  // Set only on the step into the limit so a clear works mid-stall.
  assign w_set = w_stall && (r_cnt == TO_PRE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ARB;
      r_last      <= IDW'(NUM_REQ - 1);
      r_grant     <= '0;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
      r_transfer  <= 1'b0;
      r_swrite    <= 1'b0;
      r_saddr     <= '0;
      r_swdata    <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;

      if (w_done) r_cnt <= '0;
      else        r_cnt <= w_cnt_nxt;

      if (w_set)                r_flag <= 1'b1;
      else if (bus.timeout_clr) r_flag <= 1'b0;

      case (r_state)
        ARB: begin
          if (w_any) begin
            r_saddr  <= bus.req_addr[int'(w_win)*DATA_W +: DATA_W];
            r_swdata <= bus.req_wdata[int'(w_win)*DATA_W +: DATA_W];
            r_swrite    <= bus.req_write[w_win];
            r_transfer  <= 1'b1;
            r_req_ready <= ONE << w_win;
            r_grant     <= w_win;
            r_last      <= w_win;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Drop transfer in SETUP so the master idles after ACCESS.
          if (w_setup) begin
            r_transfer <= 1'b0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (w_done) begin
            r_rsp_rdata <= bus.PRDATA;
            r_rsp_err   <= bus.PSLVERR;
            r_rsp_valid <= ONE << r_grant;
            r_busy      <= 1'b0;
            r_state     <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign bus.transfer     = r_transfer;
  assign bus.SWRITE       = r_swrite;
  assign bus.SADDR        = r_saddr;
  assign bus.SWDATA       = r_swdata;
  assign bus.req_ready    = r_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.busy         = r_busy;
  assign bus.grant_id     = r_grant;
  assign bus.timeout_flag = r_flag;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with an APB master/slave model
// and a response scoreboard.
module tb_apb_req_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus();

  apb_req_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );

  int          m_st;
  int          s_cnt;
  int          s_wait;
  logic        s_err;
  logic [DW-1:0] s_rdata;
  int          cyc = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  // APB master: IDLE(0) -> SETUP(1) -> ACCESS(2); slave wait states.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_st  <= 0;
      s_cnt <= 0;
    end else begin
      case (m_st)
        0: if (bus.transfer) m_st <= 1;
        1: m_st <= 2;
        2: if (bus.PREADY) m_st <= bus.transfer ? 1 : 0;
        default: m_st <= 0;
      endcase
      if (m_st == 2 && !bus.PREADY) s_cnt <= s_cnt + 1;
      else s_cnt <= 0;
    end
  end

  assign bus.PSEL    = (m_st != 0);
  assign bus.PENABLE = (m_st == 2);
  assign bus.PREADY  = (m_st == 2) && (s_cnt >= s_wait);
  assign bus.PSLVERR = (m_st == 2) && s_err;
  assign bus.PRDATA  = bus.PENABLE ? s_rdata : '0;

  typedef struct {
    int          id;
    logic        err;
    logic        rd_chk;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic err,
                      input logic rd_chk,
                      input logic [DW-1:0] rd);
    exp_t e;
    e.id = id;
    e.err = err;
    e.rd_chk = rd_chk;
    e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic drive(input int id, input logic wr,
                       input logic [DW-1:0] a,
                       input logic [DW-1:0] d);
    bus.req_valid[id] = 1'b1;
    bus.req_write[id] = wr;
    bus.req_addr[id*DW +: DW] = a;
    bus.req_wdata[id*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_rsp(input int max);
    int n;
    n = 0;
    while (bus.rsp_valid == 0 && n < max) begin
      tick();
      n++;
    end
    chk("rsp_wait", 64'(bus.rsp_valid != 0), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        {bus.transfer, bus.SWRITE, bus.busy,
         bus.rsp_err, bus.timeout_flag}, 0);
    chk({tag, "_saddr"}, bus.SADDR, 0);
    chk({tag, "_swdata"}, bus.SWDATA, 0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_pulses"}, {bus.req_ready, bus.rsp_valid}, 0);
    chk({tag, "_grant"}, bus.grant_id, 0);
  endtask

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge PCLK) begin : mon
    exp_t e;
    if (PRESETn && bus.rsp_valid != 0) begin
      rsp_seen++;
      if (sb.size() == 0) begin
        chk("sb_unexpected", bus.rsp_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_id", bus.rsp_valid, 64'(1) << e.id);
        chk("sb_err", bus.rsp_err, e.err);
        if (e.rd_chk) chk("sb_rdata", bus.rsp_rdata, e.rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int n;
    bus.req_valid   = '0;
    bus.req_write   = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.timeout_clr = 1'b0;
    s_wait  = 0;
    s_err   = 1'b0;
    s_rdata = '0;

    repeat (3) @(posedge PCLK);
    #1;
    chk_zero("rst");
    @(negedge PCLK) PRESETn = 1'b1;

    // Single zero-wait write from requester 0.
    @(negedge PCLK);
    push(0, 1'b0, 1'b0, '0);
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    chk("t1_ready", bus.req_ready, 4'b0001);
    chk("t1_saddr", bus.SADDR, 32'h10);
    chk("t1_swdata", bus.SWDATA, 32'hDEADBEEF);
    chk("t1_swrite", bus.SWRITE, 1);
    chk("t1_xfer_e0", bus.transfer, 1);
    chk("t1_grant", bus.grant_id, 0);
    chk("t1_busy", bus.busy, 1);
    bus.req_valid = '0;
    tick();
    chk("t1_xfer_e1", bus.transfer, 1);
    tick();
    chk("t1_xfer_e2", bus.transfer, 0);
    chk("t1_rsp_e2", bus.rsp_valid, 0);
    tick();
    chk("t1_rsp_e3", bus.rsp_valid, 4'b0001);
    chk("t1_err", bus.rsp_err, 0);
    tick();
    chk("t1_rsp_pulse", bus.rsp_valid, 0);
    chk("t1_idle", bus.busy, 0);

    // Read with two wait states from requester 2.
    s_wait  = 2;
    s_rdata = 32'h12345678;
    push(2, 1'b0, 1'b1, 32'h12345678);
    drive(2, 1'b0, 32'h20, 32'h0);
    tick();
    chk("t2_ready", bus.req_ready, 4'b0100);
    chk("t2_saddr", bus.SADDR, 32'h20);
    chk("t2_swrite", bus.SWRITE, 0);
    bus.req_valid = '0;
    repeat (4) tick();
    chk("t2_rsp_e4", bus.rsp_valid, 0);
    tick();
    chk("t2_rsp_e5", bus.rsp_valid, 4'b0100);
    chk("t2_rdata", bus.rsp_rdata, 32'h12345678);
    tick();

    // Twenty stalled access cycles from requester 3.
    s_wait  = 20;
    s_rdata = 32'hA5A50003;
    push(3, 1'b0, 1'b1, 32'hA5A50003);
    drive(3, 1'b0, 32'h30, 32'h0);
    tick();
    chk("to_ready", bus.req_ready, 4'b1000);
    bus.req_valid = '0;
    repeat (17) tick();
    chk("to_flag_e17", bus.timeout_flag, 0);
    tick();
    chk("to_flag_e18", bus.timeout_flag, 1);
    chk("to_busy", bus.busy, 1);
    repeat (4) tick();
    chk("to_rsp_e22", bus.rsp_valid, 0);
    tick();
    chk("to_rsp_e23", bus.rsp_valid, 4'b1000);
    tick();
    chk("to_flag_held", bus.timeout_flag, 1);
    bus.timeout_clr = 1'b1;
    tick();
    bus.timeout_clr = 1'b0;
    chk("to_flag_clr", bus.timeout_flag, 0);
    s_wait = 0;

    // All four requesting: strict rotation, 4-cycle spacing.
    for (int k = 0; k < 8; k++) push(k % 4, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) drive(k, 1'b1, 32'h100 + k, k);
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n = 1;
      while (bus.req_ready == 0 && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("rr_grant%0d", k), bus.req_ready,
          64'(1) << (k % 4));
      if (k > 0) chk($sformatf("rr_gap%0d", k), cyc - prev, 4);
      prev = cyc;
    end
    bus.req_valid = '0;
    wait_rsp(10);
    tick();

    // Slave error on requester 1, then a clean read on requester 2.
    s_err = 1'b1;
    push(1, 1'b1, 1'b0, '0);
    drive(1, 1'b1, 32'h44, 32'h55);
    tick();
    chk("err_ready", bus.req_ready, 4'b0010);
    bus.req_valid = '0;
    wait_rsp(10);
    chk("err_rsp", bus.rsp_valid, 4'b0010);
    chk("err_flag", bus.rsp_err, 1);
    tick();
    s_err = 1'b0;
    s_rdata = 32'hCAFE0002;
    push(2, 1'b0, 1'b1, 32'hCAFE0002);
    drive(2, 1'b0, 32'h48, 32'h0);
    tick();
    chk("post_err_ready", bus.req_ready, 4'b0100);
    chk("post_err_saddr", bus.SADDR, 32'h48);
    bus.req_valid = '0;
    wait_rsp(10);
    chk("post_err_rsp", bus.rsp_valid, 4'b0100);
    chk("post_err_err", bus.rsp_err, 0);
    tick();

    // Reset while requester 3 sits in a stalled access phase.
    s_wait = 5;
    drive(3, 1'b1, 32'h3C, 32'h77);
    tick();
    chk("mr_ready", bus.req_ready, 4'b1000);
    bus.req_valid = '0;
    repeat (3) tick();
    chk("mr_busy", bus.busy, 1);
    chk("mr_grant", bus.grant_id, 3);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk_zero("mr_async");
    @(negedge PCLK);
    PRESETn = 1'b1;
    s_wait = 0;
    push(0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) drive(k, 1'b1, 32'h200 + k, k);
    tick();
    chk("mr_first_ready", bus.req_ready, 4'b0001);
    chk("mr_first_grant", bus.grant_id, 0);
    bus.req_valid = '0;
    wait_rsp(10);
    tick();
    tick();

    chk("sb_empty", sb.size(), 0);
    chk("rsp_count", rsp_seen, 14);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
